aurora_rx_deframer: RTL
=======================

Name: aurora_rx_deframer

Overview:
- Receive-side counterpart of the lane data controller. Sits after the per-lane 8b/10b decoder in single-lane mode.
- Consumes decoded 2-byte words with K flags. Strips SCP/ECP delimiters, idles and clock-compensation characters and PAD.
- Emits frame payload as an AXI-stream-like output with last, keep and error flag. Aurora RX has no backpressure, so there is no ready input.

Parameters:
CNT_WIDTH, 16, width of good-frame counter
ERR_CNT_WIDTH, 8, width of saturating error counter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
channel_up  input  1  RX channel init complete; low forces IDLE
rx_valid  input  1  rx_data/rx_k/rx_code_err valid this cycle
rx_data  input  16  decoded word; [15:8] = byte0 (first on wire), [7:0] = byte1
rx_k  input  2  K flag per byte; [1] = byte0, [0] = byte1
rx_code_err  input  1  decoder code/disparity error on this word
m_axi_valid  output  1  output beat valid
m_axi_data  output  16  payload word, byte0 in [15:8]
m_axi_keep  output  2  byte enables; 2'b11 full, 2'b10 byte0 only
m_axi_last  output  1  final beat of frame
m_axi_err  output  1  frame corrupt; meaningful only with m_axi_last
frame_err  output  1  one-cycle pulse per protocol/code error
frame_count  output  CNT_WIDTH  frames ended by ECP with err=0, wraps
err_count  output  ERR_CNT_WIDTH  frame_err pulses, saturates at all-ones

Behaviour:
- Word classes (rx_valid=1):
  - SCP: rx_k=11, data=16'h5CFB.
  - ECP: rx_k=11, data=16'hFDFE.
  - IDLE: rx_k=11, each byte in {BC,1C,7C,F7}.
  - DATA: rx_k=00.
  - PADW: rx_k=01, byte1=9C.
  - Any other K combination is BADK.
- rx_valid=0: no state or output change, except that all outputs go to 0/deasserted for that cycle.
- Reset: state=IDLE, hold empty. All outputs 0; counters 0.
- Holding register (hold_v, hold_data, hold_keep, pad_seen) plus sticky bad flag.
- Every output is registered: a beat caused by the input at cycle N is visible at N+1.
- m_axi_valid is a single-cycle beat per event. Idle cycles output valid=0, last=0, err=0.
- State IDLE:
  - SCP -> IN_FRAME; hold_v=0, bad=0, pad_seen=0.
  - IDLE word -> ignored.
  - DATA, PADW, ECP, BADK -> frame_err pulse; stay IDLE.
  - rx_code_err -> frame_err pulse.
- State IN_FRAME:
  - DATA with pad_seen=0: if hold_v, emit hold (last=0). Then hold <= word, keep=11, hold_v=1.
  - PADW with pad_seen=0: emit hold if hold_v. Then hold <= word, keep=10, pad_seen=1.
  - IDLE: ignored; hold unchanged. Clock compensation inside a frame is legal.
  - ECP with hold_v=1: emit hold with last=1, err=bad. frame_count++ if bad=0. -> IDLE.
  - ECP with hold_v=0 (empty frame): no beat, no count, no error. -> IDLE.
  - DATA or PADW after pad_seen: frame_err; bad=1; word dropped.
  - BADK: frame_err; bad=1; word dropped.
  - SCP: frame_err. If hold_v, emit hold with last=1, err=1. Restart frame in IN_FRAME with hold_v=0, bad=0.
  - rx_code_err=1: frame_err; bad=1; word still classified and processed. An ECP with a code error therefore ends the frame with err=1.
- channel_up=0, in any state, overrides rx_valid:
  - If IN_FRAME and hold_v, emit hold with last=1, err=1 and pulse frame_err.
  - State -> IDLE; hold cleared. Counters retained.
- frame_count wraps at 2^CNT_WIDTH. err_count saturates and does not wrap.
- At most one beat and one frame_err pulse per cycle.

Test Plan:
- SCP, DATA 1122, DATA 3344, ECP -> beats {1122,keep=11,last=0}, {3344,keep=11,last=1,err=0}. Last beat appears on the cycle after ECP; frame_count=1.
- SCP, DATA AABB, IDLE BCBC, PADW CC9C, ECP -> beats {AABB,last=0}, {CC9C,keep=10,last=1,err=0}; frame_count=1.
- SCP, ECP -> no beats, frame_count=0, err_count=0.
- SCP, DATA 0102, DATA 0304 with rx_code_err=1, ECP -> last beat {0304,last=1,err=1}; frame_err pulses once; err_count=1; frame_count=0.
- SCP, DATA 5555, SCP, DATA 6666, ECP -> beat {5555,last=1,err=1} with frame_err pulse, then {6666,last=1,err=0}; frame_count=1.
- SCP, DATA 7777, channel_up=0 -> beat {7777,last=1,err=1}; state IDLE. Then 300 frame errors -> err_count stays at 255.

Source files
------------

// File: rtl/aurora_rx_deframer.sv
// aurora_rx_deframer: strips SCP/ECP/idle/pad from decoded 2-byte words and emits framed payload beats
module aurora_rx_deframer #(
  parameter int CNT_WIDTH     = 16,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     channel_up,
  input  logic                     rx_valid,
  input  logic [15:0]              rx_data,
  input  logic [1:0]               rx_k,
  input  logic                     rx_code_err,
  output logic                     m_axi_valid,
  output logic [15:0]              m_axi_data,
  output logic [1:0]               m_axi_keep,
  output logic                     m_axi_last,
  output logic                     m_axi_err,
  output logic                     frame_err,
  output logic [CNT_WIDTH-1:0]     frame_count,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);
  typedef enum logic {IDLE, IN_FRAME} state_t;
  state_t state_q, state_d;
  logic hold_v_q, hold_v_d, pad_seen_q, pad_seen_d, bad_q, bad_d;
  logic [15:0] hold_data_q, hold_data_d;
  logic [1:0] hold_keep_q, hold_keep_d;
  logic valid_q, valid_d, last_q, last_d, err_q, err_d, ferr_q, ferr_d;
  logic [15:0] data_q, data_d;
  logic [1:0] keep_q, keep_d;
  logic [CNT_WIDTH-1:0] fc_q, fc_d;
  logic [ERR_CNT_WIDTH-1:0] ec_q, ec_d;
  logic is_scp, is_ecp, is_idle, is_data, is_pad, is_badk, b0_idle, b1_idle;
  logic beat, last, err, fc_inc;
  assign b0_idle = rx_data[15:8] inside {8'hBC, 8'h1C, 8'h7C, 8'hF7};
  assign b1_idle = rx_data[7:0] inside {8'hBC, 8'h1C, 8'h7C, 8'hF7};
  assign is_scp  = rx_k == 2'b11 && rx_data == 16'h5CFB;
  assign is_ecp  = rx_k == 2'b11 && rx_data == 16'hFDFE;
  assign is_idle = rx_k == 2'b11 && b0_idle && b1_idle;
  assign is_data = rx_k == 2'b00;
  assign is_pad  = rx_k == 2'b01 && rx_data[7:0] == 8'h9C;
  assign is_badk = !(is_scp || is_ecp || is_idle || is_data || is_pad);
  always_comb begin
    state_d     = state_q;
    hold_v_d    = hold_v_q;
    hold_data_d = hold_data_q;
    hold_keep_d = hold_keep_q;
    pad_seen_d  = pad_seen_q;
    bad_d       = bad_q;
    beat        = 1'b0;
    last        = 1'b0;
    err         = 1'b0;
    ferr_d      = 1'b0;
    fc_inc      = 1'b0;
    if (!channel_up) begin
      if (state_q == IN_FRAME && hold_v_q) begin
        beat   = 1'b1;
        last   = 1'b1;
        err    = 1'b1;
        ferr_d = 1'b1;
      end
      state_d    = IDLE;
      hold_v_d   = 1'b0;
      pad_seen_d = 1'b0;
      bad_d      = 1'b0;
    end else if (rx_valid) begin
      if (state_q == IDLE) begin
        ferr_d = rx_code_err || is_data || is_pad || is_ecp || is_badk;
        if (is_scp) begin
          state_d    = IN_FRAME;
          hold_v_d   = 1'b0;
          bad_d      = 1'b0;
          pad_seen_d = 1'b0;
        end
      end else begin
        ferr_d = rx_code_err;
        bad_d  = bad_q || rx_code_err;
        if ((is_data || is_pad) && !pad_seen_q) begin
          beat        = hold_v_q;
          hold_data_d = rx_data;
          hold_keep_d = is_pad ? 2'b10 : 2'b11;
          hold_v_d    = 1'b1;
          pad_seen_d  = is_pad;
        end else if (is_data || is_pad || is_badk) begin
          ferr_d = 1'b1;
          bad_d  = 1'b1;
        end else if (is_ecp) begin
          beat       = hold_v_q;
          last       = 1'b1;
          err        = bad_d;
          fc_inc     = hold_v_q && !bad_d;
          state_d    = IDLE;
          hold_v_d   = 1'b0;
          pad_seen_d = 1'b0;
        end else if (is_scp) begin
          ferr_d     = 1'b1;
          beat       = hold_v_q;
          last       = 1'b1;
          err        = 1'b1;
          hold_v_d   = 1'b0;
          bad_d      = 1'b0;
          pad_seen_d = 1'b0;
        end
      end
    end
    valid_d = beat;
    data_d  = beat ? hold_data_q : 16'h0000;
    keep_d  = beat ? hold_keep_q : 2'b00;
    last_d  = beat && last;
    err_d   = beat && err;
    fc_d    = fc_q + CNT_WIDTH'(fc_inc);
    ec_d    = ec_q + ERR_CNT_WIDTH'(ferr_d && !(&ec_q));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_v_q    <= 1'b0;
      hold_data_q <= '0;
      hold_keep_q <= '0;
      pad_seen_q  <= 1'b0;
      bad_q       <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      keep_q      <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      ferr_q      <= 1'b0;
      fc_q        <= '0;
      ec_q        <= '0;
    end else begin
      state_q     <= state_d;
      hold_v_q    <= hold_v_d;
      hold_data_q <= hold_data_d;
      hold_keep_q <= hold_keep_d;
      pad_seen_q  <= pad_seen_d;
      bad_q       <= bad_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
      last_q      <= last_d;
      err_q       <= err_d;
      ferr_q      <= ferr_d;
      fc_q        <= fc_d;
      ec_q        <= ec_d;
    end
  end
  assign m_axi_valid = valid_q;
  assign m_axi_data  = data_q;
  assign m_axi_keep  = keep_q;
  assign m_axi_last  = last_q;
  assign m_axi_err   = err_q;
  assign frame_err   = ferr_q;
  assign frame_count = fc_q;
  assign err_count   = ec_q;
endmodule
